data_memory_controller: RTL and testbench

Sequential MEM-stage bridge between the byte-enable logic and the data-memory bus of the RV32I 5-stage core. It accepts one load/store per MEM-stage occupancy and runs a valid/ready request plus a response handshake on the bus. It stalls the pipeline until the access completes. It returns read data right-aligned by the byte offset, so byte/half extraction downstream always sees the addressed lane in bits [7:0]/[15:0].

---
 rtl/data_memory_controller_pkg.sv | 54 +++++
 rtl/data_memory_controller_load_data_aligner.sv | 14 +
 rtl/data_memory_controller.sv | 175 +++++++++++++++++
 tb/tb_data_memory_controller.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_controller_pkg.sv
// Shared definitions for the MEM-stage data memory controller: FSM state
// encodings, load/store funct3 width codes and the alignment check.
package data_memory_controller_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_REQ      = 2'd1;
    localparam logic [1:0] ST_WAIT_RSP = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    // Load width codes (funct3)
    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    // Store width codes (funct3)
    localparam logic [2:0] STORE_SB = 3'b000;
    localparam logic [2:0] STORE_SH = 3'b001;
    localparam logic [2:0] STORE_SW = 3'b010;

    // True when the access cannot be issued on the bus: halfword on an odd
    // byte, word off a word boundary, or a store with no byte strobes.
    function automatic logic is_misaligned(
        input logic       is_load,
        input logic [2:0] f3,
        input logic [1:0] offset,
        input logic [3:0] mask
    );
        logic mis;
        mis = 1'b0;
        if (is_load) begin
            case (f3)
                LOAD_LB, LOAD_LBU: mis = 1'b0;
                LOAD_LH, LOAD_LHU: mis = offset[0];
                LOAD_LW:           mis = (offset != 2'b00);
                default:           mis = 1'b0;
            endcase
        end else begin
            case (f3)
                STORE_SB: mis = 1'b0;
                STORE_SH: mis = offset[0];
                STORE_SW: mis = (offset != 2'b00);
                default:  mis = 1'b0;
            endcase
            if (mask == 4'b0000) begin
                mis = 1'b1;
            end
        end
        return mis;
    endfunction

endpackage

// File: rtl/data_memory_controller_load_data_aligner.sv
// Right-aligns a bus read word by the access byte offset so the addressed
// byte/halfword lands in the low lanes; vacated upper lanes are zero-filled.
module load_data_aligner (
    input  logic [31:0] data_i,
    input  logic [1:0]  offset_i,
    output logic [31:0] data_o
);

    // Logical shift right by 8*offset
    always_comb begin
        data_o = data_i >> {offset_i, 3'b000};
    end

endmodule

// File: rtl/data_memory_controller.sv
// MEM-stage bridge between the byte-enable logic and the data-memory bus.
// Issues one valid/ready request per load/store, waits for the response
// (bounded by TIMEOUT_CYCLES), stalls the pipeline meanwhile and presents
// aligned read data and trap flags in DONE until the stage advances.
module data_memory_controller
    import data_memory_controller_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memory_read,
    input  logic        memory_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [3:0]  write_mask,
    input  logic        mem_stage_hold,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        misaligned,
    output logic        access_fault,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_addr,
    output logic        bus_write,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rsp_error
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0]      read_data_q, read_data_d;
    logic             misaligned_q, misaligned_d;
    logic             access_fault_q, access_fault_d;
    logic             req_valid_q, req_valid_d;
    logic [31:0]      addr_q, addr_d;
    logic             write_q, write_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [1:0]       offset_q, offset_d;

    logic             access;
    logic             is_load;
    logic             access_misaligned;
    logic [31:0]      aligned_rdata;

    assign access            = memory_read | memory_write;
    assign is_load           = memory_read;
    assign access_misaligned = is_misaligned(is_load, funct3, address[1:0], write_mask);
    assign cnt_inc           = cnt_q + CNT_W'(1);

    load_data_aligner u_load_data_aligner (
        .data_i   (bus_rdata),
        .offset_i (offset_q),
        .data_o   (aligned_rdata)
    );

    // Next-state and registered-output update for the access FSM
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        read_data_d    = read_data_q;
        misaligned_d   = misaligned_q;
        access_fault_d = access_fault_q;
        req_valid_d    = req_valid_q;
        addr_d         = addr_q;
        write_d        = write_q;
        wdata_d        = wdata_q;
        wstrb_d        = wstrb_q;
        offset_d       = offset_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (access) begin
                    if (access_misaligned) begin
                        state_d        = ST_DONE;
                        misaligned_d   = 1'b1;
                        access_fault_d = 1'b0;
                        read_data_d    = '0;
                    end else begin
                        state_d     = ST_REQ;
                        req_valid_d = 1'b1;
                        addr_d      = {address[31:2], 2'b00};
                        offset_d    = address[1:0];
                        write_d     = ~is_load;
                        wdata_d     = write_data;
                        wstrb_d     = is_load ? 4'b0000 : write_mask;
                    end
                end
            end

            ST_REQ: begin
                if (bus_req_ready) begin
                    state_d     = ST_WAIT_RSP;
                    req_valid_d = 1'b0;
                    cnt_d       = '0;
                end
            end

            ST_WAIT_RSP: begin
                if (bus_rsp_valid) begin
                    state_d        = ST_DONE;
                    read_data_d    = write_q ? 32'h0 : aligned_rdata;
                    access_fault_d = bus_rsp_error;
                end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_d        = ST_DONE;
                    read_data_d    = '0;
                    access_fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_DONE: begin
                if (!mem_stage_hold) begin
                    state_d        = ST_IDLE;
                    misaligned_d   = 1'b0;
                    access_fault_d = 1'b0;
                    read_data_d    = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            read_data_q    <= '0;
            misaligned_q   <= 1'b0;
            access_fault_q <= 1'b0;
            req_valid_q    <= 1'b0;
            addr_q         <= '0;
            write_q        <= 1'b0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            offset_q       <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            read_data_q    <= read_data_d;
            misaligned_q   <= misaligned_d;
            access_fault_q <= access_fault_d;
            req_valid_q    <= req_valid_d;
            addr_q         <= addr_d;
            write_q        <= write_d;
            wdata_q        <= wdata_d;
            wstrb_q        <= wstrb_d;
            offset_q       <= offset_d;
        end
    end

    assign read_data     = read_data_q;
    assign misaligned    = misaligned_q;
    assign access_fault  = access_fault_q;
    assign bus_req_valid = req_valid_q;
    assign bus_addr      = addr_q;
    assign bus_write     = write_q;
    assign bus_wdata     = wdata_q;
    assign bus_wstrb     = wstrb_q;
    assign stall         = (state_q != ST_DONE) & access;

endmodule

// File: tb/tb_data_memory_controller.sv
// Scoreboard bench for data_memory_controller: a driver plays pipeline and
// bus, pushing model expectations into a queue; a negedge monitor checks
// bus payload, stall length and DONE results against the queue head.
module tb_data_memory_controller;
    import data_memory_controller_pkg::*;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        memory_read, memory_write;
    logic [2:0]  funct3;
    logic [31:0] address, write_data;
    logic [3:0]  write_mask;
    logic        mem_stage_hold;
    logic [31:0] read_data;
    logic        stall, misaligned, access_fault;
    logic        bus_req_valid, bus_req_ready;
    logic [31:0] bus_addr;
    logic        bus_write;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rsp_valid;
    logic [31:0] bus_rdata;
    logic        bus_rsp_error;

    typedef struct {
        bit          is_load;
        bit          both;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] rdata;
        bit          err;
        int unsigned ready_dly;
        int unsigned rsp_dly;
        bit          never;
        int unsigned hold;
    } txn_t;

    typedef struct {
        logic        mis;
        logic        fault;
        logic [31:0] rd;
        logic [31:0] baddr;
        logic        bwrite;
        logic [31:0] bwdata;
        logic [3:0]  bwstrb;
        int unsigned stalls;
    } exp_t;

    exp_t        expq[$];
    int          n_tests;
    int          n_fail;
    bit          started;
    int unsigned stall_cnt;
    bit          in_done;
    exp_t        mon_e;

    data_memory_controller #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .memory_read    (memory_read),
        .memory_write   (memory_write),
        .funct3         (funct3),
        .address        (address),
        .write_data     (write_data),
        .write_mask     (write_mask),
        .mem_stage_hold (mem_stage_hold),
        .read_data      (read_data),
        .stall          (stall),
        .misaligned     (misaligned),
        .access_fault   (access_fault),
        .bus_req_valid  (bus_req_valid),
        .bus_req_ready  (bus_req_ready),
        .bus_addr       (bus_addr),
        .bus_write      (bus_write),
        .bus_wdata      (bus_wdata),
        .bus_wstrb      (bus_wstrb),
        .bus_rsp_valid  (bus_rsp_valid),
        .bus_rdata      (bus_rdata),
        .bus_rsp_error  (bus_rsp_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected outcome from access width, offset and bus behaviour
    function automatic exp_t model(input txn_t t);
        exp_t        e;
        int unsigned sz;
        int unsigned off;
        sz  = (t.f3[1:0] == 2'd0) ? 1 : (t.f3[1:0] == 2'd1) ? 2 : 4;
        off = t.addr % 4;
        e.mis    = ((t.addr % sz) != 0) || (!t.is_load && t.mask == 4'h0);
        e.baddr  = t.addr - off;
        e.bwrite = !t.is_load;
        e.bwdata = t.wdata;
        e.bwstrb = t.is_load ? 4'h0 : t.mask;
        if (e.mis) begin
            e.fault  = 1'b0;
            e.rd     = 32'h0;
            e.stalls = 1;
        end else if (t.never || t.rsp_dly >= TO) begin
            e.fault  = 1'b1;
            e.rd     = 32'h0;
            e.stalls = 1 + (t.ready_dly + 1) + TO;
        end else begin
            e.fault  = t.err;
            e.rd     = t.is_load ? (t.rdata >> (8 * off)) : 32'h0;
            e.stalls = 1 + (t.ready_dly + 1) + (t.rsp_dly + 1);
        end
        return e;
    endfunction

    function automatic txn_t make_txn(
        input bit is_load, input logic [2:0] f3, input logic [31:0] addr,
        input logic [31:0] wdata, input logic [3:0] mask, input logic [31:0] rdata,
        input int unsigned rdly, input int unsigned sdly, input bit never, input int unsigned hold
    );
        txn_t t;
        t.is_load = is_load; t.both = 1'b0; t.f3 = f3; t.addr = addr;
        t.wdata = wdata; t.mask = mask; t.rdata = rdata; t.err = 1'b0;
        t.ready_dly = rdly; t.rsp_dly = sdly; t.never = never; t.hold = hold;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t        t;
        logic [2:0]  lf3 [5];
        int unsigned sz;
        lf3[0] = LOAD_LB; lf3[1] = LOAD_LH; lf3[2] = LOAD_LW; lf3[3] = LOAD_LBU; lf3[4] = LOAD_LHU;
        t.is_load = $urandom_range(0, 1) == 1;
        t.both    = t.is_load && ($urandom_range(0, 3) == 0);
        t.f3      = t.is_load ? lf3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
        t.addr    = $urandom;
        sz        = (t.f3[1:0] == 2'd0) ? 1 : (t.f3[1:0] == 2'd1) ? 2 : 4;
        if ($urandom_range(0, 1) == 1) t.addr = t.addr & ~(sz - 1);
        t.wdata     = $urandom;
        t.mask      = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom);
        t.rdata     = $urandom;
        t.err       = $urandom_range(0, 7) == 0;
        t.ready_dly = $urandom_range(0, 3);
        t.rsp_dly   = $urandom_range(0, 9);
        t.never     = $urandom_range(0, 15) == 0;
        t.hold      = $urandom_range(0, 2);
        return t;
    endfunction

    task automatic run_txn(input txn_t t);
        int unsigned rw, sw, cyc;
        bit          hs, rv, handshook, responded, stray;
        expq.push_back(model(t));
        memory_read    = t.is_load;
        memory_write   = !t.is_load || t.both;
        funct3         = t.f3;
        address        = t.addr;
        write_data     = t.wdata;
        write_mask     = t.mask;
        mem_stage_hold = 1'b0;
        rw = 0; sw = 0; cyc = 0; handshook = 0; responded = 0;
        forever begin
            hs = bus_req_valid && bus_req_ready;
            rv = bus_rsp_valid;
            @(posedge clk); #1;
            cyc++;
            if (hs) handshook = 1;
            if (rv) responded = 1;
            bus_req_ready = 1'b0;
            bus_rsp_valid = 1'b0;
            if (!stall) break;
            if (cyc > 100) begin
                n_tests++; n_fail++;
                $display("FAIL txn_complete: no completion after %0d cycles, required completion", cyc);
                expq.delete();
                memory_read = 1'b0; memory_write = 1'b0;
                reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
                return;
            end
            if (bus_req_valid) begin
                bus_req_ready = (rw == t.ready_dly);
                rw++;
            end else if (handshook && !responded && !t.never) begin
                bus_rsp_valid = (sw == t.rsp_dly);
                bus_rdata     = t.rdata;
                bus_rsp_error = t.err;
                sw++;
            end
        end
        // DONE: hold, with stray responses that must be ignored
        stray = $urandom_range(0, 1) == 1;
        for (int unsigned h = 0; h < t.hold; h++) begin
            mem_stage_hold = 1'b1;
            bus_rsp_valid  = stray;
            bus_rdata      = $urandom;
            bus_rsp_error  = 1'b1;
            @(posedge clk); #1;
        end
        mem_stage_hold = 1'b0;
        bus_rsp_valid  = stray;
        bus_rdata      = $urandom;
        @(posedge clk); #1;
        bus_rsp_valid  = 1'b0;
        bus_rsp_error  = 1'b0;
        memory_read    = 1'b0;
        memory_write   = 1'b0;
    endtask

    task automatic idle_gap(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            bus_rsp_valid = $urandom_range(0, 1) == 1;
            bus_rdata     = $urandom;
            @(posedge clk); #1;
        end
        bus_rsp_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_read_data"},     read_data,             32'h0);
        check({tag, "_misaligned"},    32'(misaligned),       32'h0);
        check({tag, "_access_fault"},  32'(access_fault),     32'h0);
        check({tag, "_bus_req_valid"}, 32'(bus_req_valid),    32'h0);
        check({tag, "_bus_addr"},      bus_addr,              32'h0);
        check({tag, "_bus_write"},     32'(bus_write),        32'h0);
        check({tag, "_bus_wdata"},     bus_wdata,             32'h0);
        check({tag, "_bus_wstrb"},     32'(bus_wstrb),        32'h0);
    endtask

    // Monitor: compares DUT outputs against the scoreboard head away from the clock edge
    always @(negedge clk) begin
        if (reset) begin
            stall_cnt = 0;
            in_done   = 0;
        end else if (!(memory_read || memory_write)) begin
            if (started) begin
                check("idle_read_data",  read_data,            32'h0);
                check("idle_misaligned", 32'(misaligned),      32'h0);
                check("idle_fault",      32'(access_fault),    32'h0);
                check("idle_req_valid",  32'(bus_req_valid),   32'h0);
                check("idle_stall",      32'(stall),           32'h0);
            end
        end else if (expq.size() > 0) begin
            mon_e = expq[0];
            if (stall) stall_cnt++;
            if (mon_e.mis) check("mis_no_req", 32'(bus_req_valid), 32'h0);
            if (bus_req_valid) begin
                check("bus_addr",  bus_addr,          mon_e.baddr);
                check("bus_write", 32'(bus_write),    32'(mon_e.bwrite));
                check("bus_wdata", bus_wdata,         mon_e.bwdata);
                check("bus_wstrb", 32'(bus_wstrb),    32'(mon_e.bwstrb));
            end
            if (!stall) begin
                if (!in_done) begin
                    check("stall_cycles", 32'(stall_cnt), 32'(mon_e.stalls));
                    in_done = 1;
                end
                check("read_data",    read_data,          mon_e.rd);
                check("misaligned",   32'(misaligned),    32'(mon_e.mis));
                check("access_fault", 32'(access_fault),  32'(mon_e.fault));
                if (!mem_stage_hold) begin
                    void'(expq.pop_front());
                    in_done   = 0;
                    stall_cnt = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // Driver: directed cases, reset-in-REQ, then randomized accesses
    initial begin
        n_tests = 0; n_fail = 0; started = 0; stall_cnt = 0; in_done = 0;
        reset = 1'b1; memory_read = 1'b0; memory_write = 1'b0; funct3 = 3'h0;
        address = 32'h0; write_data = 32'h0; write_mask = 4'h0; mem_stage_hold = 1'b0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = 32'h0; bus_rsp_error = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        check("reset_stall", 32'(stall), 32'h0);
        reset = 1'b0;
        started = 1;
        @(posedge clk); #1;

        // LB at 0x1003, zero-wait bus
        run_txn(make_txn(1, LOAD_LB, 32'h0000_1003, 32'h0, 4'h0, 32'hAABB_CCDD, 0, 0, 0, 0));
        idle_gap(1);
        // SH at 0x2002, ready after 4 cycles
        run_txn(make_txn(0, STORE_SH, 32'h0000_2002, 32'h5678_5678, 4'hC, 32'h0, 4, 0, 0, 0));
        idle_gap(1);
        // Misaligned LW and SW with no strobes
        run_txn(make_txn(1, LOAD_LW, 32'h0000_3001, 32'h0, 4'h0, 32'h1234_5678, 0, 0, 0, 1));
        run_txn(make_txn(0, STORE_SW, 32'h0000_3000, 32'hDEAD_BEEF, 4'h0, 32'h0, 0, 0, 0, 0));
        // Timeout with a late response, and a response on the last legal cycle
        run_txn(make_txn(1, LOAD_LW, 32'h0000_5000, 32'h0, 4'h0, 32'h1111_2222, 1, 0, 1, 2));
        idle_gap(2);
        run_txn(make_txn(1, LOAD_LHU, 32'h0000_5006, 32'h0, 4'h0, 32'h8765_4321, 0, TO - 1, 0, 0));
        run_txn(make_txn(1, LOAD_LW, 32'h0000_5008, 32'h0, 4'h0, 32'h9999_0000, 0, TO, 0, 0));
        // LW held in DONE for 3 cycles
        run_txn(make_txn(1, LOAD_LW, 32'h0000_6004, 32'h0, 4'h0, 32'hCAFE_F00D, 2, 1, 0, 3));
        idle_gap(1);

        // Reset while in REQ
        memory_read = 1'b1; funct3 = LOAD_LW; address = 32'h0000_4004;
        write_data = 32'hA5A5_5A5A; write_mask = 4'hF;
        @(posedge clk); #1;
        check("rst_req_valid_before", 32'(bus_req_valid), 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_all_zero("rst_mid");
        reset = 1'b0; memory_read = 1'b0;
        bus_rsp_valid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus_rsp_valid = 1'b0;
        check("rst_stray_read_data", read_data, 32'h0);
        check("rst_stray_req_valid", 32'(bus_req_valid), 32'h0);
        idle_gap(1);

        for (int i = 0; i < 200; i++) begin
            run_txn(rand_txn());
            if ($urandom_range(0, 2) == 0) idle_gap($urandom_range(1, 2));
        end

        repeat (3) @(posedge clk);
        if (expq.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
